// File: rtl/fb_lut_loader_pkg.sv
// Shared definitions for the BPM gain-scale LUT loader: command fields,
// target codes, FSM states and default bus widths.
package fb_lut_loader_pkg;

    localparam int ADDR_W_DEF   = 15;
    localparam int DATA_W_DEF   = 7;
    localparam int CMD_SYNC_BIT = 7;
    localparam int CMD_RW_BIT   = 6;

    typedef enum logic [1:0] {
        TGT_BPM1_I = 2'd0,
        TGT_BPM1_Q = 2'd1,
        TGT_BPM2_I = 2'd2,
        TGT_BPM2_Q = 2'd3
    } target_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_AHI,
        ST_ALO,
        ST_NHI,
        ST_NLO,
        ST_WR_DATA,
        ST_WR_CSUM,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_RD_CSUM
    } state_e;

    // A command byte needs the sync bit set and its reserved field clear.
    function automatic logic cmd_valid(input logic [7:0] cmd);
        return cmd[CMD_SYNC_BIT] && (cmd[5:2] == 4'd0);
    endfunction

endpackage

// File: rtl/fb_lut_loader_if.sv
// Host byte interface of the LUT loader: rx stream in, tx readback stream out.
interface fb_lut_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/fb_lut_loader_rdmux.sv
// Registered 4:1 select of the LUT readback ports, with a valid strobe that
// lines up with the data once the LUT read latency has elapsed.
module fb_lut_rdmux
    import fb_lut_loader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_i,
    input  logic [1:0]             sel_i,
    input  logic [3:0][DATA_W-1:0] doutb_i,
    output logic [DATA_W-1:0]      data_o,
    output logic                   valid_o
);

    // One stage for the address register, RD_LAT for the LUT, one for data_q.
    localparam int DEPTH = RD_LAT + 2;

    logic [DEPTH-1:0]  vld_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= {vld_q[DEPTH-2:0], issue_i};
            data_q <= doutb_i[sel_i];
        end
    end

    assign data_o  = data_q;
    assign valid_o = vld_q[DEPTH-1];

endmodule

// File: rtl/fb_lut_loader.sv
// Framed host-byte loader for the four BPM gain-scale LUT B-ports: streams
// writes straight into the selected LUT and returns checksummed readback.
module fb_lut_loader
    import fb_lut_loader_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    fb_lut_loader_if.slave    host,
    output logic [DATA_W-1:0] bpm_lut_dinb,
    output logic [ADDR_W-1:0] bpm_lut_addrb,
    output logic              bpm1_i_lut_web,
    output logic              bpm1_q_lut_web,
    output logic              bpm2_i_lut_web,
    output logic              bpm2_q_lut_web,
    input  logic [DATA_W-1:0] bpm1_i_lut_doutb,
    input  logic [DATA_W-1:0] bpm1_q_lut_doutb,
    input  logic [DATA_W-1:0] bpm2_i_lut_doutb,
    input  logic [DATA_W-1:0] bpm2_q_lut_doutb,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    target_e           tgt_q, tgt_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [3:0]        web_q, web_d;
    logic [DATA_W-1:0] dinb_q, dinb_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;
    logic [7:0]        txd_q, txd_d;

    logic              rx_ready;
    logic              tx_valid;
    logic              rx_fire;
    logic              tx_fire;
    logic              rd_issue;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [15:0]       n_full;

    fb_lut_rdmux #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rdmux (
        .clk     (clk),
        .rst     (rst),
        .issue_i (rd_issue),
        .sel_i   (tgt_q),
        .doutb_i ({bpm2_q_lut_doutb, bpm2_i_lut_doutb, bpm1_q_lut_doutb, bpm1_i_lut_doutb}),
        .data_o  (rd_data),
        .valid_o (rd_valid)
    );

    // WR_DATA drops rx_ready once the count is spent so the final web pulse
    // still lands while the FSM is in WR_DATA.
    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_AHI, ST_ALO, ST_NHI, ST_NLO, ST_WR_CSUM: rx_ready = 1'b1;
            ST_WR_DATA: rx_ready = (cnt_q != 16'd0);
            default:    rx_ready = 1'b0;
        endcase
    end

    assign tx_valid = (state_q == ST_RD_SEND) || (state_q == ST_RD_CSUM);
    assign rx_fire  = host.rx_valid && rx_ready;
    assign tx_fire  = tx_valid && host.tx_ready;
    assign n_full   = {cnt_q[15:8], host.rx_data};

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        err_d    = err_q;
        done_d   = 1'b0;
        web_d    = '0;
        dinb_d   = dinb_q;
        addrb_d  = addrb_q;
        txd_d    = txd_q;
        rd_issue = 1'b0;
        tmo_d    = '0;

        if ((state_q != ST_IDLE) && rx_ready && !rx_fire) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            ST_IDLE: if (rx_fire) begin
                if (cmd_valid(host.rx_data)) begin
                    err_d   = 1'b0;
                    tgt_d   = target_e'(host.rx_data[1:0]);
                    rd_d    = host.rx_data[CMD_RW_BIT];
                    csum_d  = host.rx_data;
                    state_d = ST_AHI;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_AHI: if (rx_fire) begin
                addr_d  = ADDR_W'({host.rx_data[6:0], 8'h00});
                csum_d  = csum_q ^ host.rx_data;
                state_d = ST_ALO;
            end
            ST_ALO: if (rx_fire) begin
                addr_d  = addr_q | ADDR_W'(host.rx_data);
                csum_d  = csum_q ^ host.rx_data;
                state_d = ST_NHI;
            end
            ST_NHI: if (rx_fire) begin
                cnt_d   = {host.rx_data, 8'h00};
                csum_d  = csum_q ^ host.rx_data;
                state_d = ST_NLO;
            end
            ST_NLO: if (rx_fire) begin
                cnt_d = n_full;
                if (rd_q) begin
                    // Readback checksum covers only the bytes sent back.
                    csum_d = 8'h00;
                    if (n_full == 16'd0) begin
                        txd_d   = 8'h00;
                        state_d = ST_RD_CSUM;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end else begin
                    csum_d  = csum_q ^ host.rx_data;
                    state_d = (n_full == 16'd0) ? ST_WR_CSUM : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_WR_CSUM;
                end else if (rx_fire) begin
                    web_d[tgt_q] = 1'b1;
                    dinb_d       = DATA_W'(host.rx_data[6:0]);
                    addrb_d      = addr_q;
                    addr_d       = addr_q + ADDR_W'(1);
                    cnt_d        = cnt_q - 16'd1;
                    csum_d       = csum_q ^ host.rx_data;
                end
            end
            ST_WR_CSUM: if (rx_fire) begin
                if (host.rx_data == csum_q) begin
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                addrb_d  = addr_q;
                rd_issue = 1'b1;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: if (rd_valid) begin
                txd_d   = 8'(rd_data);
                state_d = ST_RD_SEND;
            end
            ST_RD_SEND: if (tx_fire) begin
                csum_d = csum_q ^ txd_q;
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    txd_d   = csum_q ^ txd_q;
                    state_d = ST_RD_CSUM;
                end else begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_CSUM: if (tx_fire) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Idle gap inside a frame on the rx side aborts it; nothing was accepted
        // this cycle, so no write can be pending from it.
        if ((state_q != ST_IDLE) && rx_ready && !rx_fire &&
            (tmo_q == TMO_W'(TIMEOUT - 1))) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tgt_q   <= TGT_BPM1_I;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            web_q   <= '0;
            dinb_q  <= '0;
            addrb_q <= '0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
            web_q   <= web_d;
            dinb_q  <= dinb_d;
            addrb_q <= addrb_d;
            txd_q   <= txd_d;
        end
    end

    assign host.rx_ready  = rx_ready;
    assign host.tx_data   = txd_q;
    assign host.tx_valid  = tx_valid;
    assign bpm_lut_dinb   = dinb_q;
    assign bpm_lut_addrb  = addrb_q;
    assign bpm1_i_lut_web = web_q[0];
    assign bpm1_q_lut_web = web_q[1];
    assign bpm2_i_lut_web = web_q[2];
    assign bpm2_q_lut_web = web_q[3];
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: doc/fb_lut_loader.md
Name: fb_lut_loader

Overview:
- Writer side of the four BPM gain-scale LUT B-ports (bpm1_i, bpm1_q, bpm2_i, bpm2_q) used by the feedback processor's LUT calculation.
- Accepts a framed byte stream from the host interface, drives the shared data/address bus plus one write-enable per LUT, and supports checksum-protected readback of any LUT.
- Sits in the slow_clk domain, between the host byte interface and the LUT B-ports.

Parameters:
- ADDR_W, 15, LUT B-port address width
- DATA_W, 7, LUT data width
- RD_LAT, 2, cycles from address change to valid doutb
- TIMEOUT, 65535, max idle cycles between bytes inside a frame before abort

Ports:
- clk  in  1  slow_clk domain clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid; byte consumed when rx_valid & rx_ready
- rx_ready  out  1  loader can accept a byte
- tx_data  out  8  readback byte
- tx_valid  out  1  tx_data valid; held stable until tx_ready
- tx_ready  in  1  host accepts tx_data
- bpm_lut_dinb  out  DATA_W  shared LUT write data
- bpm_lut_addrb  out  ADDR_W  shared LUT address
- bpm1_i_lut_web, bpm1_q_lut_web, bpm2_i_lut_web, bpm2_q_lut_web  out  1 each  per-LUT write enable
- bpm1_i_lut_doutb, bpm1_q_lut_doutb, bpm2_i_lut_doutb, bpm2_q_lut_doutb  in  DATA_W each  LUT readback data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse on good frame end
- err  out  1  sticky error; cleared by the next valid command byte

Behaviour:
- Reset: all outputs 0 except rx_ready=1; state IDLE; address, length and checksum registers 0.
- Frame: CMD, A_HI, A_LO, N_HI, N_LO, then either N write data bytes + one checksum byte (write), or nothing further from the host (read).
- Start address = {A_HI[6:0], A_LO}; A_HI[7] ignored.
- CMD fields: bit7 = 1 (sync), bit6 = 1 for read / 0 for write, bits[5:2] = 0, bits[1:0] = target (0 bpm1_i, 1 bpm1_q, 2 bpm2_i, 3 bpm2_q).
- Bad CMD (bit7 = 0 or bits[5:2] != 0): set err, stay IDLE, consume the byte.
- States: IDLE -> AHI -> ALO -> NHI -> NLO -> (WR_DATA | RD_ISSUE). Any header byte advances one state.
- Write path:
  - WR_DATA: each byte drives dinb = byte[6:0] and addrb = current address; the target web pulses high for exactly one cycle in the cycle after acceptance; address increments.
  - Bytes are written as received, not buffered; a checksum error only flags err.
  - After N bytes -> WR_CSUM; N = 0 goes straight to WR_CSUM.
- Checksum: running XOR of all frame bytes from CMD onward. Checksum byte equal to the running XOR -> done pulse, err unchanged; otherwise err = 1. Either case returns to IDLE.
- Read path:
  - rx_ready = 0 from NLO acceptance until return to IDLE.
  - RD_ISSUE: present address -> RD_WAIT for RD_LAT cycles -> RD_SEND with tx_data = {1'b0, doutb of target}, tx_valid = 1.
  - On tx_ready: increment address, decrement count, back to RD_ISSUE.
  - After N bytes: RD_CSUM sends the XOR of all tx bytes, then done, then IDLE. N = 0 sends only a checksum of 0x00.
- Address wrap: 0x7FFF + 1 -> 0x0000, silently.
- Timeout:
  - Counter clears on every accepted rx byte or tx handshake and counts otherwise while busy.
  - Reaching TIMEOUT in any rx-waiting state: err = 1, return to IDLE, no web.
  - No timeout while waiting on tx_ready.
- At most one web high per cycle. web is never high outside WR_DATA. dinb and addrb hold their last values when idle.
- rst mid-frame: immediate return to reset state; a web scheduled for the next cycle is suppressed.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - CMD field constants: SYNC bit, RW bit, target codes.
  - State enum.
  - ADDR_W/DATA_W defaults.
- Sub-module fb_lut_rdmux: registered 4:1 doutb select with RD_LAT alignment. Everything else stays in the top FSM.

Test Plan:
- Write bpm2_q: frame 0x83,0x01,0x00,0x00,0x03, data 0x11,0x22,0x33, correct checksum -> bpm2_q web pulses at addr 0x0100/0x0101/0x0102 with dinb 0x11/0x22/0x33; done pulse; err = 0.
- Write bpm1_i with wrong checksum at addr 0x7FFF, N = 2 -> writes land at 0x7FFF and 0x0000 (wrap); err = 1; no done.
- Read bpm1_q, N = 2, start 0x0100, model returns 0x05/0x7F with RD_LAT = 2, tx_ready stalled 10 cycles on the first byte -> tx 0x05, 0x7F, checksum 0x7A; tx_data stable during the stall; done pulse.
- Bad CMD 0x44 -> err = 1, IDLE; a following valid CMD 0x80 clears err.
- Stop after N_HI for TIMEOUT cycles (TIMEOUT = 100 in bench) -> err = 1 at cycle 100, IDLE, no web.
- Assert rst between data bytes 1 and 2 of a write -> no further web, outputs at reset values, next frame completes normally.
